// File: rtl/dmem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams a host image into data memory, then releases the core.
// Host writes reach the memory one cycle after accept; s_ready drops once all words are taken.
module dmem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic             halt,
  input  logic             cpu_MemWrite,
  input  logic [31:0]      cpu_DataAdr,
  input  logic [31:0]      cpu_WriteData,
  output logic             cpu_reset,
  output logic             MemWrite,
  output logic [31:0]      DataAdr,
  output logic [31:0]      WriteData,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_DRAIN,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic              len_err_q, len_err_d;
  logic              wr_pend_q, wr_pend_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;

  logic              len_over;
  logic [IDX_W-1:0]  len_clamp;
  logic [IDX_W-1:0]  idx_inc;

  // Compare at 32 bits so any LEN_W clamps correctly against MAX_WORDS.
  assign len_over  = (32'(load_len) > 32'(MAX_WORDS));
  assign len_clamp = len_over ? IDX_W'(MAX_WORDS) : IDX_W'(load_len);
  assign idx_inc   = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    s_ready   = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (start) begin
          len_d     = len_clamp;
          len_err_d = len_over;
          idx_d     = '0;
          state_d   = (len_clamp == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = (idx_q < len_q);
        if (s_valid && s_ready) begin
          wr_pend_d = 1'b1;
          wr_data_d = s_data;
          wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
          idx_d     = idx_inc;
          if (idx_inc == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      idx_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  // The memory port belongs to the core only in RUN; otherwise the write register owns it.
  always_comb begin
    cpu_reset = (state_q != S_RUN);
    busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    done      = done_q;
    len_err   = len_err_q;
    MemWrite  = wr_pend_q;
    DataAdr   = wr_addr_q;
    WriteData = wr_data_q;
    if (state_q == S_RUN) begin
      MemWrite  = cpu_MemWrite;
      DataAdr   = cpu_DataAdr;
      WriteData = cpu_WriteData;
    end
  end

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Directed bench for dmem_boot_loader: cycle vector table plus hand sequences for long/reset cases.
module tb_dmem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] load_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        halt;
  logic        cpu_MemWrite;
  logic [31:0] cpu_DataAdr;
  logic [31:0] cpu_WriteData;

  logic        s_ready, cpu_reset, MemWrite, busy, done, len_err;
  logic [31:0] DataAdr, WriteData;
  logic        w_s_ready, w_cpu_reset, w_MemWrite, w_busy, w_done, w_len_err;
  logic [31:0] w_DataAdr, w_WriteData;

  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

  dmem_boot_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .halt(halt),
    .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr), .cpu_WriteData(cpu_WriteData),
    .cpu_reset(cpu_reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .len_err(len_err)
  );

  dmem_boot_loader #(.BASE_ADDR(WRAP_BASE), .MAX_WORDS(64), .LEN_W(16)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(w_s_ready), .halt(halt),
    .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr), .cpu_WriteData(cpu_WriteData),
    .cpu_reset(w_cpu_reset), .MemWrite(w_MemWrite), .DataAdr(w_DataAdr), .WriteData(w_WriteData),
    .busy(w_busy), .done(w_done), .len_err(w_len_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        chk;
    logic        rst, st;
    logic [15:0] len;
    logic        sv;
    logic [31:0] sd;
    logic        hlt, cwe;
    logic [31:0] cadr, cwd;
    logic [5:0]  e;      // {cpu_reset, s_ready, MemWrite, busy, done, len_err}
    logic        bus;
    logic [31:0] eadr, ewd;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic chk, rst, st, input logic [15:0] len,
                              input logic sv, input logic [31:0] sd, input logic hlt, cwe,
                              input logic [31:0] cadr, cwd, input logic [5:0] e,
                              input logic bus, input logic [31:0] eadr, ewd, input logic wrap);
    vec_t v;
    v.chk = chk; v.rst = rst; v.st = st; v.len = len; v.sv = sv; v.sd = sd;
    v.hlt = hlt; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd; v.e = e;
    v.bus = bus; v.eadr = eadr; v.ewd = ewd; v.wrap = wrap;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] flags;
  int         acc, wcnt, bad;
  logic       seen;
  logic [31:0] last_adr;

  assign flags = {cpu_reset, s_ready, MemWrite, busy, done, len_err};

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
    halt = 1'b0; cpu_MemWrite = 1'b0; cpu_DataAdr = '0; cpu_WriteData = '0;

    // Load of 3 with s_valid held high, then RUN passthrough and halt.
    vecs.push_back(mk(0,1,0,0, 0,0, 0,0,0,0,       6'b000000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b100000,1,0,0,0));
    vecs.push_back(mk(1,0,1,3, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 1,32'hA, 0,0,0,0,   6'b110100,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 1,32'hB, 0,0,0,0,   6'b111100,1,32'h0,32'hA,1));
    vecs.push_back(mk(1,0,0,0, 1,32'hC, 0,0,0,0,   6'b111100,1,32'h4,32'hB,1));
    vecs.push_back(mk(1,0,0,0, 1,32'hD, 0,0,0,0,   6'b101100,1,32'h8,32'hC,1));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b000010,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,1,32'h20,32'h55, 6'b001000,1,32'h20,32'h55,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,1,32'h20,32'h55, 6'b001000,1,32'h20,32'h55,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,1,32'h20,32'h55, 6'b100000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));
    // Same load with s_valid toggling.
    vecs.push_back(mk(1,0,1,3, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 1,32'hA, 0,0,0,0,   6'b110100,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,32'hE, 0,0,0,0,   6'b111100,1,32'h0,32'hA,0));
    vecs.push_back(mk(1,0,0,0, 1,32'hB, 0,0,0,0,   6'b110100,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,32'hE, 0,0,0,0,   6'b111100,1,32'h4,32'hB,0));
    vecs.push_back(mk(1,0,0,0, 1,32'hC, 0,0,0,0,   6'b110100,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b101100,1,32'h8,32'hC,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b000010,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,0,0,0,       6'b000000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));
    // Zero-length load: HOLD -> DRAIN -> RUN.
    vecs.push_back(mk(1,0,1,0, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b100100,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b000010,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,0,0,0,       6'b000000,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0,       6'b100000,0,0,0,0));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; load_len = vecs[i].len;
      s_valid = vecs[i].sv; s_data = vecs[i].sd; halt = vecs[i].hlt;
      cpu_MemWrite = vecs[i].cwe; cpu_DataAdr = vecs[i].cadr; cpu_WriteData = vecs[i].cwd;
      #2;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d", i),
              {26'b0, flags, (vecs[i].bus ? DataAdr : vecs[i].eadr), (vecs[i].bus ? WriteData : vecs[i].ewd)},
              {26'b0, vecs[i].e, vecs[i].eadr, vecs[i].ewd});
        if (vecs[i].wrap)
          check($sformatf("wrap%0d", i), {63'b0, w_MemWrite, w_DataAdr},
                {63'b0, 1'b1, vecs[i].eadr + WRAP_BASE});
      end
      cyc();
    end

    // Oversized load: clamp to 64 words, flag len_err.
    reset = 1'b0; halt = 1'b0; cpu_MemWrite = 1'b0; s_valid = 1'b0;
    start = 1'b1; load_len = 16'd100;
    cyc();
    start = 1'b0; s_valid = 1'b1;
    acc = 0; wcnt = 0; bad = 0; seen = 1'b0; last_adr = '0;
    for (int c = 0; c < 300 && !seen; c++) begin
      s_data = 32'h1000 + 32'(acc);
      #2;
      if (c == 0) check("len_err_set", {95'b0, len_err}, {95'b0, 1'b1});
      if (s_ready && s_valid) acc++;
      if (MemWrite) begin
        if (DataAdr !== 32'(wcnt << 2) || WriteData !== 32'h1000 + 32'(wcnt)) bad++;
        last_adr = DataAdr;
        wcnt++;
      end
      if (done) seen = 1'b1;
      else cyc();
    end
    check("long_done_seen", {95'b0, seen}, {95'b0, 1'b1});
    check("long_write_cnt", 96'(wcnt), 96'd64);
    check("long_last_adr", {64'b0, last_adr}, {64'b0, 32'h0000_00FC});
    check("long_bad_writes", 96'(bad), 96'd0);
    s_valid = 1'b0; halt = 1'b1;
    cyc();
    halt = 1'b0;

    // Next start with an in-range length clears len_err.
    start = 1'b1; load_len = 16'd2;
    cyc();
    start = 1'b0;
    #2;
    check("len_err_clear", {90'b0, flags}, {90'b0, 6'b110100});
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Reset after 2 of 5 words, then a fresh load restarts at BASE_ADDR.
    start = 1'b1; load_len = 16'd5;
    cyc();
    start = 1'b0; s_valid = 1'b1; s_data = 32'h11;
    cyc();
    s_data = 32'h22;
    cyc();
    s_valid = 1'b0; reset = 1'b1;
    #2;
    check("pre_reset_wr", {31'b0, MemWrite, DataAdr, WriteData}, {31'b0, 1'b1, 32'h4, 32'h22});
    cyc();
    reset = 1'b0;
    #2;
    check("mid_reset_hold", {26'b0, flags, DataAdr, WriteData}, {26'b0, 6'b100000, 32'h0, 32'h0});
    cyc();
    start = 1'b1; load_len = 16'd5;
    cyc();
    start = 1'b0; s_valid = 1'b1; s_data = 32'h99;
    cyc();
    s_valid = 1'b0;
    #2;
    check("reload_first_wr", {31'b0, MemWrite, DataAdr, WriteData}, {31'b0, 1'b1, 32'h0, 32'h99});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
